// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and width helpers for the sequential FIR filter.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Wide enough that a sum of TAPS full-precision products can never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction
endpackage

// File: rtl/fir_mac_bank.sv
// fir_mac_bank: MACS parallel signed multipliers summed to one ACC_W-wide partial sum.
module fir_mac_bank #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 9,
  parameter int MACS = 4,
  parameter int ACC_W = 21
) (
  input  logic signed [DATA_W-1:0] x [MACS],
  input  logic signed [COEF_W-1:0] c [MACS],
  output logic signed [ACC_W-1:0]  sum
);
  localparam int PROD_W = DATA_W + COEF_W;
  logic signed [PROD_W-1:0] prod [MACS];
  always_comb begin
    sum = '0;
    for (int j = 0; j < MACS; j++) begin
      prod[j] = PROD_W'(x[j]) * PROD_W'(c[j]);
      sum = sum + ACC_W'(prod[j]);
    end
  end
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, MACS taps per cycle with programmable coefficients.
// Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 9,
  parameter int TAPS = 16,
  parameter int MACS = 4,
  parameter int OUT_W = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_sample,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_result,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      coef_busy
);
  localparam int P = TAPS / MACS;
  localparam int PW = P > 1 ? clog2(P) : 1;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int SW = ACC_W > OUT_W ? ACC_W : OUT_W;
  state_t state, state_nx;
  logic [PW-1:0] p;
  logic last;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [DATA_W-1:0] xs [P][MACS];
  logic signed [COEF_W-1:0] cs [P][MACS];
  logic signed [DATA_W-1:0] x_lane [MACS];
  logic signed [COEF_W-1:0] c_lane [MACS];
  logic signed [ACC_W-1:0] part, acc, acc_nx;
  logic signed [SW-1:0] shifted;
  logic signed [OUT_W-1:0] scaled;
  // Taps regrouped by phase so each lane is a P-way mux on p.
  for (genvar g = 0; g < P; g++) begin : g_phase
    for (genvar j = 0; j < MACS; j++) begin : g_lane
      assign xs[g][j] = x[g*MACS+j];
      assign cs[g][j] = c[g*MACS+j];
    end
  end
  always_comb begin
    for (int j = 0; j < MACS; j++) begin
      x_lane[j] = xs[p][j];
      c_lane[j] = cs[p][j];
    end
  end
  fir_mac_bank #(.DATA_W(DATA_W), .COEF_W(COEF_W), .MACS(MACS), .ACC_W(ACC_W)) u_bank (
    .x(x_lane),
    .c(c_lane),
    .sum(part)
  );
  assign last = p == PW'(P - 1);
  assign acc_nx = (p == '0 ? '0 : acc) + part;
  assign shifted = SW'(acc_nx) >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
  localparam logic signed [SW-1:0] SMAX = (SW'(1) <<< (OUT_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  assign scaled = shifted > SMAX ? OUT_W'(SMAX) : shifted < SMIN ? OUT_W'(SMIN) : OUT_W'(shifted);
`else
  assign scaled = OUT_W'(shifted);
`endif
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (in_valid ? ACCUM : IDLE)
             : state == ACCUM ? (last ? OUT : ACCUM)
             : state == OUT && !out_ready ? OUT : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == OUT;
    coef_busy = state != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      out_result <= '0;
      p <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      if (state == IDLE && coef_we && int'(coef_addr) < TAPS) c[coef_addr] <= coef_data;
      if (state == IDLE && in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
        x[0] <= in_sample;
        p <= '0;
      end
      if (state == ACCUM) begin
        acc <= acc_nx;
        p <= p + PW'(1);
        if (last) out_result <= scaled;
      end
    end
  end
endmodule
